// File: rtl/wmux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wmux_pkg
// Description : Shared definitions for the bus-matrix data multiplexers.
//               Holds default configuration constants, the grant-class
//               enumeration and a one-hot-to-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wmux_pkg;

    localparam int WMUX_NUM_M = 16;
    localparam int WMUX_DW    = 39;
    localparam int WMUX_DEF_M = 0;
    localparam int WMUX_ECW   = 8;

    typedef enum logic [1:0] {
        GNT_ZERO  = 2'd0,
        GNT_ONE   = 2'd1,
        GNT_MULTI = 2'd2
    } gnt_class_e;

    // Index of the set bit of a one-hot vector (up to 32 masters).
    // Result is only meaningful for a true one-hot input.
    function automatic logic [4:0] onehot_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wdata_mux_n_gnt_classify.sv
`default_nettype none
// ============================================================================
// Module      : gnt_classify
// Description : Purely combinational grant classifier. Counts the bits set
//               in the address-phase grant and reports ZERO / ONE / MULTI
//               together with the index of the granted master. Shared by the
//               write-data and read-data multiplexers.
// Ports       : gnt  [N-1:0]  in   grant vector (expected one-hot or zero)
//               cls            out  grant class
//               idx  [IW-1:0]  out  granted master index (valid for ONE)
// Revision    : 1.0 - initial release
// ============================================================================
module gnt_classify
    import wmux_pkg::*;
#(
    parameter int N  = WMUX_NUM_M,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  gnt,
    output gnt_class_e    cls,
    output logic [IW-1:0] idx
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + CW'(gnt[i]);
        end
    end

    always_comb begin
        if (w_pop == '0) begin
            cls = GNT_ZERO;
        end else if (w_pop == CW'(1)) begin
            cls = GNT_ONE;
        end else begin
            cls = GNT_MULTI;
        end
    end

    assign idx = IW'(onehot_idx(32'(gnt)));

endmodule
`default_nettype wire

// File: rtl/wdata_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : wdata_mux_n
// Description : Write-data multiplexer for one slave port of the bus matrix.
//               The one-hot address-phase grant is latched when the slave
//               accepts the address phase (MsRDY high) and steers the master
//               write data during the following data phase. Also tracks
//               data-phase validity and flags multi-hot (illegal) grants with
//               a sticky flag and a saturating counter.
// Config      : `define WDATA_MUX_HOLD_EN to hold the last driven write data
//               while no master is selected instead of driving DEF_M data.
// Ports       : CLK, nRST (async, active-low)
//               MsRDY    in   slave ready / address-phase accept
//               AmCMUX   in   [NUM_M]     address-phase one-hot grant
//               AmVLD    in   address phase carries a real transfer
//               MxWDT    in   [NUM_M*DW]  master write data, master i at i*DW
//               err_clr  in   clear sel_err / err_cnt
//               MmWDT    out  [DW]        selected write data
//               dp_sel   out  [NUM_M]     latched data-phase select
//               dp_vld   out  data phase is a valid granted transfer
//               sel_err  out  sticky illegal-grant flag
//               err_cnt  out  [ECW]       saturating illegal-grant count
// Revision    : 1.0 - initial release
// ============================================================================
module wdata_mux_n
    import wmux_pkg::*;
#(
    parameter int NUM_M = WMUX_NUM_M,
    parameter int DW    = WMUX_DW,
    parameter int DEF_M = WMUX_DEF_M,
    parameter int ECW   = WMUX_ECW
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                MsRDY,
    input  logic [NUM_M-1:0]    AmCMUX,
    input  logic                AmVLD,
    input  logic [NUM_M*DW-1:0] MxWDT,
    input  logic                err_clr,
    output logic [DW-1:0]       MmWDT,
    output logic [NUM_M-1:0]    dp_sel,
    output logic                dp_vld,
    output logic                sel_err,
    output logic [ECW-1:0]      err_cnt
);

    localparam int               IW      = $clog2(NUM_M);
    localparam logic [NUM_M-1:0] DEF_SEL = {{(NUM_M-1){1'b0}}, 1'b1} << DEF_M;
    localparam logic [IW-1:0]    DEF_IDX = IW'(DEF_M);

    gnt_class_e    w_cls;
    logic [IW-1:0] w_gidx;
    logic [IW-1:0] r_idx;     // index companion of dp_sel, drives the mux
    logic [DW-1:0] w_idle_data;
    logic [DW-1:0] w_sel_data;

    gnt_classify #(
        .N  (NUM_M),
        .IW (IW)
    ) u_gnt_classify (
        .gnt (AmCMUX),
        .cls (w_cls),
        .idx (w_gidx)
    );

    // Data-phase select, validity and illegal-grant tracking
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dp_sel  <= '0;
            dp_vld  <= 1'b0;
            r_idx   <= DEF_IDX;
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (MsRDY) begin
                case (w_cls)
                    GNT_ONE: begin
                        dp_sel <= AmCMUX;
                        dp_vld <= AmVLD;
                        r_idx  <= w_gidx;
                    end
                    GNT_MULTI: begin
                        // Park on the default master; never a valid transfer
                        dp_sel <= DEF_SEL;
                        dp_vld <= 1'b0;
                        r_idx  <= DEF_IDX;
                    end
                    default: begin
                        dp_sel <= '0;
                        dp_vld <= 1'b0;
                        r_idx  <= DEF_IDX;
                    end
                endcase
            end

            // A new illegal grant takes priority over a simultaneous clear,
            // so the event that coincided with the clear is still counted.
            if (MsRDY && (w_cls == GNT_MULTI)) begin
                sel_err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= ECW'(1);
                end else if (err_cnt != {ECW{1'b1}}) begin
                    err_cnt <= err_cnt + ECW'(1);
                end
            end else if (err_clr) begin
                sel_err <= 1'b0;
                err_cnt <= '0;
            end
        end
    end

    assign w_sel_data = MxWDT[int'(r_idx)*DW +: DW];

`ifdef WDATA_MUX_HOLD_EN
    logic [DW-1:0] hold_q;

    // Remember the last data driven while a master was selected so the idle
    // bus does not toggle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_q <= '0;
        end else if (dp_sel != '0) begin
            hold_q <= MmWDT;
        end
    end

    assign w_idle_data = hold_q;
`else
    assign w_idle_data = MxWDT[DEF_M*DW +: DW];
`endif

    assign MmWDT = (dp_sel != '0) ? w_sel_data : w_idle_data;

endmodule
`default_nettype wire

// File: tb/tb_wdata_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_wdata_mux_n
// Description : Self-checking bench for wdata_mux_n with directed scenarios
//               and randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wdata_mux_n;

    localparam int NUM_M = 16;
    localparam int DW    = 39;
    localparam int DEF_M = 0;
    localparam int ECW   = 8;
    localparam int CMAX  = (1 << ECW) - 1;

    logic                CLK;
    logic                nRST;
    logic                MsRDY;
    logic [NUM_M-1:0]    AmCMUX;
    logic                AmVLD;
    logic [NUM_M*DW-1:0] MxWDT;
    logic                err_clr;
    logic [DW-1:0]       MmWDT;
    logic [NUM_M-1:0]    dp_sel;
    logic                dp_vld;
    logic                sel_err;
    logic [ECW-1:0]      err_cnt;

    logic [DW-1:0] md [NUM_M];

    int n_tests;
    int n_fail;

    // Reference model state: selected master (-1 = none), flags, counter
    int            m_sel;
    bit            m_vld;
    bit            m_err;
    int            m_cnt;
    logic [DW-1:0] m_hold;

    wdata_mux_n #(
        .NUM_M (NUM_M),
        .DW    (DW),
        .DEF_M (DEF_M),
        .ECW   (ECW)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .MsRDY   (MsRDY),
        .AmCMUX  (AmCMUX),
        .AmVLD   (AmVLD),
        .MxWDT   (MxWDT),
        .err_clr (err_clr),
        .MmWDT   (MmWDT),
        .dp_sel  (dp_sel),
        .dp_vld  (dp_vld),
        .sel_err (sel_err),
        .err_cnt (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            MxWDT[i*DW +: DW] = md[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_out();
        if (m_sel >= 0) return md[m_sel];
`ifdef WDATA_MUX_HOLD_EN
        return m_hold;
`else
        return md[DEF_M];
`endif
    endfunction

    function automatic logic [NUM_M-1:0] exp_sel();
        logic [NUM_M-1:0] one;
        one = 1;
        return (m_sel >= 0) ? (one << m_sel) : '0;
    endfunction

    task automatic model_reset();
        m_sel  = -1;
        m_vld  = 0;
        m_err  = 0;
        m_cnt  = 0;
        m_hold = '0;
    endtask

    // Apply the rules for one rising edge using the inputs present at it
    task automatic model_edge();
        int pop;
        int who;
        pop = $countones(AmCMUX);
        who = 0;
        for (int i = 0; i < NUM_M; i++) if (AmCMUX[i]) who = i;
        if (m_sel >= 0) m_hold = exp_out();
        if (MsRDY) begin
            if (pop == 0) begin
                m_sel = -1; m_vld = 0;
            end else if (pop == 1) begin
                m_sel = who; m_vld = AmVLD;
            end else begin
                m_sel = DEF_M; m_vld = 0;
            end
        end
        if (MsRDY && pop > 1) begin
            m_err = 1;
            m_cnt = err_clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        end else if (err_clr) begin
            m_err = 0;
            m_cnt = 0;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".MmWDT"},   64'(MmWDT),   64'(exp_out()));
        chk({tag, ".dp_sel"},  64'(dp_sel),  64'(exp_sel()));
        chk({tag, ".dp_vld"},  64'(dp_vld),  64'(m_vld));
        chk({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_cnt));
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM_M; i++) md[i] = {7'($urandom), $urandom};
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        nRST    = 1'b0;
        MsRDY   = 1'b0;
        AmCMUX  = '0;
        AmVLD   = 1'b0;
        err_clr = 1'b0;
        rand_data();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset");
        nRST = 1'b1;
        tick("rst_release");

        // Single grant to M3, then stall with a changing grant
        AmCMUX = 16'h0008; AmVLD = 1'b1; MsRDY = 1'b1;
        tick("grant_m3");
        chk("m3_data", 64'(MmWDT), 64'(md[3]));
        MsRDY = 1'b0; AmCMUX = 16'h0100;
        repeat (3) tick("stall");
        chk("stall_m3_data", 64'(MmWDT), 64'(md[3]));

        // Illegal grant, then saturate the counter
        AmCMUX = 16'h0011; MsRDY = 1'b1; AmVLD = 1'b1;
        tick("multi");
        chk("multi_cnt1", 64'(err_cnt), 64'd1);
        repeat (299) tick("multi_rep");
        chk("sat_cnt", 64'(err_cnt), 64'(CMAX));

        // Clear coinciding with an illegal grant, then clear alone
        err_clr = 1'b1;
        tick("clr_multi");
        chk("clr_multi_cnt", 64'(err_cnt), 64'd1);
        AmCMUX = 16'h0000; MsRDY = 1'b0;
        tick("clr_alone");
        chk("clr_alone_err", 64'(sel_err), 64'd0);
        err_clr = 1'b0;

        // Idle after M5: data follows DEF_M or stays held
        md[5] = 39'h5A5A;
        AmCMUX = 16'h0020; MsRDY = 1'b1;
        tick("grant_m5");
        AmCMUX = 16'h0000;
        tick("idle_m5");
        md[0] = 39'h1_2345_6789; md[5] = 39'h7_0F0F_0F0F;
        tick("idle_chg");
`ifdef WDATA_MUX_HOLD_EN
        chk("idle_hold", 64'(MmWDT), 64'h5A5A);
`else
        chk("idle_def", 64'(MmWDT), 64'(md[0]));
`endif

        // Asynchronous reset in the middle of an M7 data phase
        AmCMUX = 16'h0080; AmVLD = 1'b1; MsRDY = 1'b1;
        tick("grant_m7");
        MsRDY = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        #1;
        nRST = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int kind;
            int a;
            int b;
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, NUM_M - 1));
            b    = (a + 1 + int'($urandom_range(0, NUM_M - 2))) % NUM_M;
            case (kind)
                0:       AmCMUX = '0;
                3:       AmCMUX = NUM_M'(1 << a) | NUM_M'(1 << b) | NUM_M'($urandom);
                default: AmCMUX = NUM_M'(1 << a);
            endcase
            AmVLD   = 1'($urandom);
            MsRDY   = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) rand_data();
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/wdata_mux_n.md
Name: wdata_mux_n

Overview:
- Parametrised write-data multiplexer for the bus matrix. Selects one of NUM_M master write-data words for a slave port.
- Latches the one-hot address-phase grant when the slave accepts the address phase (MsRDY high), then uses the latched select during the following data phase.
- Adds three functions: data-phase valid tracking, detection of illegal (multi-hot) grants with a sticky error flag and a saturating count, and an optional hold of the last driven data while idle.

Parameters:
- NUM_M, 16, number of masters (2..32)
- DW, 39, write-data word width per master
- DEF_M, 0, default master index, driven when no master is selected
- ECW, 8, width of the error counter

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- MsRDY  in  1  slave ready; high ends the current data phase and accepts the next address phase
- AmCMUX  in  NUM_M  address-phase grant, one-hot; all-zero means no master
- AmVLD  in  1  address phase carries a real transfer
- MxWDT  in  NUM_M*DW  concatenated master write data; master i occupies bits [i*DW +: DW]
- err_clr  in  1  synchronous clear for sel_err and err_cnt
- MmWDT  out  DW  selected write data
- dp_sel  out  NUM_M  latched data-phase select, one-hot or zero
- dp_vld  out  1  current data phase is a valid granted transfer
- sel_err  out  1  sticky illegal-grant flag
- err_cnt  out  ECW  saturating count of illegal grants

Behaviour:
- Reset values: dp_sel=0, dp_vld=0, sel_err=0, err_cnt=0. MmWDT is combinational and equals master DEF_M data during reset.
- Capture happens only at a posedge with MsRDY=1. With MsRDY=0, dp_sel, dp_vld, sel_err and err_cnt all hold.
- Grant classification (combinational, by popcount of AmCMUX):
  - ZERO (0 bits set): dp_sel<=0, dp_vld<=0.
  - ONE (1 bit set): dp_sel<=AmCMUX, dp_vld<=AmVLD.
  - MULTI (>1 bits set): dp_sel<=one-hot(DEF_M), dp_vld<=0, sel_err<=1, err_cnt increments.
- err_cnt saturates at 2^ECW-1 and never wraps.
- err_clr=1 at a posedge clears sel_err and err_cnt, independent of MsRDY.
- err_clr coinciding with a MULTI capture: the error wins, giving sel_err=1 and err_cnt=1.
- MmWDT selection, zero latency from dp_sel (combinational):
  - dp_sel one-hot at bit i: MmWDT = master i data.
  - dp_sel zero: MmWDT = master DEF_M data (or held data, see Optional Feature).
- AmCMUX changes while MsRDY=0 have no effect on MmWDT.
- Back-to-back transfers: a new grant takes effect on MmWDT in the cycle after the accepting MsRDY edge, with no bubble.
- Asserting nRST mid-data-phase drops dp_sel and dp_vld to 0 immediately (asynchronous).

Optional Feature:
- Macro: WDATA_MUX_HOLD_EN.
- Defined: adds register hold_q (DW bits, reset 0). hold_q loads MmWDT at every posedge where dp_sel is non-zero. When dp_sel is zero, MmWDT = hold_q instead of master DEF_M data. This reduces toggling on an idle slave bus.
- Undefined: no hold_q; zero select drives master DEF_M data.

Decomposition:
- Package wmux_pkg holds:
  - default NUM_M/DW/DEF_M/ECW constants
  - grant-class enum {GNT_ZERO, GNT_ONE, GNT_MULTI}
  - function onehot_idx (one-hot to index).
- One sub-module is natural: gnt_classify. It is purely combinational: popcount of AmCMUX in, grant class and index out. It is reused by the read-data mux.

Test Plan:
- Reset release, AmCMUX=0: MmWDT=M0 data, dp_vld=0, sel_err=0, err_cnt=0.
- AmCMUX=16'h0008, AmVLD=1, MsRDY=1 at edge: next cycle dp_sel=16'h0008, dp_vld=1, MmWDT=M3 data. Hold MsRDY=0 for 3 cycles while changing AmCMUX to 16'h0100: MmWDT stays M3 data.
- AmCMUX=16'h0011, MsRDY=1: sel_err=1, err_cnt=1, dp_vld=0, MmWDT=M0 data. Repeat 300 times with ECW=8: err_cnt=255.
- err_clr=1 coinciding with a MULTI grant capture: sel_err=1, err_cnt=1. err_clr alone: both 0 on the next cycle.
- With WDATA_MUX_HOLD_EN defined: grant M5 (data 39'h5A5A), then AmCMUX=0 at an MsRDY edge, then change M0/M5 data: MmWDT stays 39'h5A5A. With the macro undefined: MmWDT follows M0 data.
- nRST asserted mid-data-phase with M7 selected: dp_sel=0 and dp_vld=0 asynchronously, MmWDT=M0 data.
